// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS subset core: add/sub/and/or/slt, addi, lw, sw, beq, j.
// One shared memory port. Each access is requested with mem_req and held
// until mem_ready; fetches use the PC and loads/stores use the ALU result.
// Optional macro ILLEGAL_TRAP_EN: when defined, an illegal instruction stops
// the core in HALT (halted=1). When undefined, it executes as a NOP.
//
// Memory handshake: while mem_req=1, mem_addr, mem_we and mem_wdata stay
// constant. The access completes on the rising edge where mem_ready=1, and
// mem_rdata is sampled on that same edge. mem_ready is ignored while
// mem_req=0. Reset removes the request asynchronously.
module multicycle_cpu #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       a_q, a_d;       // rs value
  logic [31:0]       b_q, b_d;       // rt value
  logic [31:0]       imm_q, imm_d;   // sign-extended imm16
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       mdr_q, mdr_d;   // load data
  logic [31:0]       rf_q [32];
  logic [31:0]       rf_d [32];

  // Instruction fields, always taken from the latched instruction.
  logic [5:0]  opcode;
  logic [4:0]  rs_idx, rt_idx, rd_idx;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] target;

  assign opcode = instr_q[31:26];
  assign rs_idx = instr_q[25:21];
  assign rt_idx = instr_q[20:16];
  assign rd_idx = instr_q[15:11];
  assign funct  = instr_q[5:0];
  assign imm16  = instr_q[15:0];
  assign target = instr_q[25:0];

  logic              is_legal;
  logic [31:0]       alu_res;
  logic [31:0]       pc_ext;
  logic [31:0]       jump_full;
  logic [31:0]       branch_off;
  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] branch_pc;
  logic [4:0]        wb_idx;
  logic [31:0]       wb_data;

  // Legality decode of the latched instruction.
  always_comb begin
    is_legal = 1'b0;
    case (opcode)
      OP_RTYPE: is_legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                           (funct == FN_AND) || (funct == FN_OR)  ||
                           (funct == FN_SLT);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  // ALU: R-type operations, otherwise rs + simm (addi and address generation).
  always_comb begin
    alu_res = a_q + imm_q;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  alu_res = a_q + b_q;
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
        default: alu_res = 32'd0;
      endcase
    end
  end

  // Branch and jump targets. pc_q already points past the current instruction.
  always_comb begin
    pc_ext             = '0;
    pc_ext[ADDR_W-1:0] = pc_q;
    jump_full          = {pc_ext[31:28], target, 2'b00};
    jump_pc            = jump_full[ADDR_W-1:0];
    branch_off         = {imm_q[29:0], 2'b00};
    branch_pc          = pc_q + branch_off[ADDR_W-1:0];
  end

  // Write-back selection: rd for R-type, rt for addi/lw; loads write memory data.
  always_comb begin
    wb_idx  = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    wb_data = (opcode == OP_LW) ? mdr_q : alu_q;
  end

  // Next-state and datapath update for every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    rf_d    = rf_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          pc_d    = pc_q + PC_INC;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rf_q[rs_idx];
        b_d     = rf_q[rt_idx];
        imm_d   = {{16{imm16[15]}}, imm16};
        state_d = EXEC;
      end
      EXEC: begin
        alu_d = alu_res;
        if (!is_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = HALT;
`else
          state_d = FETCH;
`endif
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_d = MEM;
            OP_BEQ: begin
              if (a_q == b_q) pc_d = branch_pc;
              state_d = FETCH;
            end
            OP_J: begin
              pc_d    = jump_pc;
              state_d = FETCH;
            end
            default: state_d = WB;  // R-type and addi
          endcase
        end
      end
      MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LW) begin
            mdr_d   = mem_rdata;
            state_d = WB;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WB: begin
        if (wb_idx != 5'd0) rf_d[wb_idx] = wb_data;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      rf_q    <= rf_d;
    end
  end

  // Memory port decoded from state; reset gates it so a request drops at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      case (state_q)
        FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
        end
        MEM: begin
          mem_req  = 1'b1;
          mem_addr = alu_q[ADDR_W-1:0];
          if (opcode == OP_SW) begin
            mem_we    = 1'b1;
            mem_wdata = b_q;
          end
        end
        default: mem_req = 1'b0;
      endcase
    end
  end

  assign instr     = instr_q;
  assign pc_out    = pc_q;
  assign dbg_state = state_q;

`ifdef ILLEGAL_TRAP_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: a word memory model answers requests with a
// programmable wait, stores are checked against an expected queue, and
// cycle-exact checks cover latencies, reset, branches, jumps and traps.
module tb_multicycle_cpu;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic              clock;
  logic              reset;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc_out;
  logic              halted;
  logic [2:0]        dbg_state;

  multicycle_cpu #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .instr     (instr),
    .pc_out    (pc_out),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          wait_cnt;
  int          ready_delay;
  logic        store_stall;
  logic        rand_delay;
  logic [31:0] mem [256];
  logic [63:0] exp_q [$];   // {addr, data} of each expected store

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  function automatic logic [31:0] spin();
    return enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
  endfunction

  // ---------------- driver tasks ----------------
  // One clock of the memory model, run at the falling edge.
  task automatic step();
    logic [63:0] e;
    @(negedge clock);
    cyc++;
    if (!reset || !mem_req) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else begin
      if (mem_ready) wait_cnt = 0;
      mem_ready = 1'b0;
      if (wait_cnt == 0 && rand_delay) ready_delay = $urandom_range(0, 3);
      if (mem_we && store_stall) begin
        wait_cnt = wait_cnt;
      end else if (wait_cnt >= ready_delay) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL store_unexpected got addr %h data %h want none", mem_addr, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
              errors++;
              $display("FAIL store_value got %h_%h want %h_%h", mem_addr, mem_wdata, e[63:32], e[31:0]);
            end
          end
          mem[mem_addr[9:2]] = mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr[9:2]];
        end
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    step();
    step();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    exp_q.delete();
    ready_delay = 0;
    store_stall = 1'b0;
    rand_delay  = 1'b0;
  endtask

  // Release between edges; cycle 0 is the period before the first rising edge.
  task automatic release_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    cyc   = -1;
  endtask

  task automatic check_stores_done(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_stores got %0d left want 0", name, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    hold_reset();
    checks++;
    if ({mem_req, mem_we, halted} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000", {mem_req, mem_we, halted});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus got %h %h want 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if (pc_out !== RESET_PC || instr !== 32'd0 || dbg_state !== S_FETCH) begin
      errors++;
      $display("FAIL reset_state got pc %h instr %h st %0d want %h 0 0", pc_out, instr, dbg_state, RESET_PC);
    end
    mem[0] = spin();
    release_reset();
    wait_cycle(0);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_first_fetch got %b %h want 1 %h", mem_req, mem_addr, RESET_PC);
    end
    wait_cycle(1);
    checks++;
    if (dbg_state !== S_DECODE || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_decode got st %0d req %b want 1 0", dbg_state, mem_req);
    end
  endtask

  task automatic test_arith();
    hold_reset();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    mem[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'd4);
    mem[5] = enc_i(6'h2B, 5'd0, 5'd0, 16'd8);
    mem[6] = spin();
    exp_q.push_back({32'h4, 32'd12});
    exp_q.push_back({32'h8, 32'd0});
    release_reset();
    wait_cycle(3);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL arith_wb_req got %b want 0", mem_req);
    end
    wait_cycle(12);
    checks++;
    if (pc_out !== 32'd12 || mem_addr !== 32'd12 || dbg_state !== S_FETCH) begin
      errors++;
      $display("FAIL arith_pc12 got pc %h addr %h st %0d want c c 0", pc_out, mem_addr, dbg_state);
    end
    checks++;
    if (instr !== enc_r(5'd1, 5'd2, 5'd3, 6'h20)) begin
      errors++;
      $display("FAIL arith_instr got %h want add", instr);
    end
    wait_cycle(30);
    check_stores_done("arith");
  endtask

  task automatic test_mem_wait();
    hold_reset();
    ready_delay = 3;
    mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
    mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'd4);
    mem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd4);
    mem[3] = enc_i(6'h2B, 5'd0, 5'd4, 16'd8);
    mem[4] = spin();
    exp_q.push_back({32'h4, 32'd12});
    exp_q.push_back({32'h8, 32'd12});
    release_reset();
    for (int c = 13; c <= 16; c++) begin
      wait_cycle(c);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h4, 32'd12}) begin
        errors++;
        $display("FAIL wait_sw_stable c%0d got %b%b %h %h want 11 4 c", c, mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    for (int c = 23; c <= 26; c++) begin
      wait_cycle(c);
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h4}) begin
        errors++;
        $display("FAIL wait_lw_stable c%0d got %b%b %h want 10 4", c, mem_req, mem_we, mem_addr);
      end
    end
    wait_cycle(45);
    check_stores_done("mem_wait");
  endtask

  task automatic test_branch();
    hold_reset();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd4);
    mem[2] = enc_i(6'h04, 5'd1, 5'd2, 16'd1);
    mem[3] = enc_i(6'h2B, 5'd0, 5'd1, 16'h20);
    mem[4] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    exp_q.push_back({32'h20, 32'd3});
    release_reset();
    wait_cycle(11);
    checks++;
    if (dbg_state !== S_FETCH || mem_addr !== 32'hC) begin
      errors++;
      $display("FAIL beq_not_taken got st %0d addr %h want 0 c", dbg_state, mem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      wait_cycle(15 + 3 * k);
      checks++;
      if (dbg_state !== S_FETCH || mem_addr !== 32'h10) begin
        errors++;
        $display("FAIL beq_loop k%0d got st %0d addr %h want 0 10", k, dbg_state, mem_addr);
      end
    end
    check_stores_done("branch");
  endtask

  task automatic test_jump();
    hold_reset();
    mem[0]  = enc_j(26'h4);
    mem[4]  = enc_j(26'h40);
    mem[64] = enc_i(6'h2B, 5'd0, 5'd0, 16'h44);
    mem[65] = spin();
    exp_q.push_back({32'h44, 32'd0});
    release_reset();
    wait_cycle(3);
    checks++;
    if (dbg_state !== S_FETCH || mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL jump_first got st %0d addr %h want 0 10", dbg_state, mem_addr);
    end
    wait_cycle(6);
    checks++;
    if (dbg_state !== S_FETCH || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL jump_0x40 got st %0d addr %h want 0 100", dbg_state, mem_addr);
    end
    wait_cycle(16);
    check_stores_done("jump");
  endtask

  task automatic test_alu();
    hold_reset();
    mem[128] = 32'h7FFF_FFFF;
    mem[0]  = enc_i(6'h23, 5'd0, 5'd1, 16'h200);
    mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
    mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3]  = enc_r(5'd3, 5'd0, 5'd4, 6'h2A);
    mem[4]  = enc_r(5'd0, 5'd2, 5'd5, 6'h22);
    mem[5]  = enc_r(5'd3, 5'd5, 5'd6, 6'h24);
    mem[6]  = enc_r(5'd3, 5'd2, 5'd7, 6'h25);
    mem[7]  = enc_r(5'd0, 5'd3, 5'd8, 6'h2A);
    mem[8]  = enc_i(6'h08, 5'd1, 5'd9, 16'hFFFF);
    for (int i = 0; i < 7; i++)
      mem[9 + i] = enc_i(6'h2B, 5'd0, 5'(3 + i), 16'(12'h180 + 4 * i));
    mem[16] = spin();
    exp_q.push_back({32'h180, 32'h8000_0000});
    exp_q.push_back({32'h184, 32'h0000_0001});
    exp_q.push_back({32'h188, 32'hFFFF_FFFF});
    exp_q.push_back({32'h18C, 32'h8000_0000});
    exp_q.push_back({32'h190, 32'h8000_0001});
    exp_q.push_back({32'h194, 32'h0000_0000});
    exp_q.push_back({32'h198, 32'h7FFF_FFFE});
    release_reset();
    wait_cycle(90);
    check_stores_done("alu");
  endtask

  task automatic test_illegal();
    hold_reset();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    mem[1] = 32'hFC00_0000;
    mem[2] = enc_r(5'd1, 5'd1, 5'd1, 6'h3F);
    mem[3] = enc_i(6'h2B, 5'd0, 5'd1, 16'h60);
    mem[4] = spin();
`ifdef ILLEGAL_TRAP_EN
    release_reset();
    wait_cycle(6);
    checks++;
    if (dbg_state !== S_EXEC || halted !== 1'b0) begin
      errors++;
      $display("FAIL trap_exec got st %0d halted %b want 2 0", dbg_state, halted);
    end
    wait_cycle(7);
    checks++;
    if (dbg_state !== S_HALT || halted !== 1'b1 || pc_out !== 32'h8 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL trap_halt got st %0d h %b pc %h req %b want 5 1 8 0", dbg_state, halted, pc_out, mem_req);
    end
    for (int c = 8; c <= 20; c += 4) begin
      wait_cycle(c);
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL trap_hold c%0d got h %b req %b want 1 0", c, halted, mem_req);
      end
    end
`else
    exp_q.push_back({32'h60, 32'd9});
    release_reset();
    wait_cycle(7);
    checks++;
    if (dbg_state !== S_FETCH || mem_addr !== 32'h8 || halted !== 1'b0) begin
      errors++;
      $display("FAIL nop_op got st %0d addr %h h %b want 0 8 0", dbg_state, mem_addr, halted);
    end
    wait_cycle(10);
    checks++;
    if (dbg_state !== S_FETCH || mem_addr !== 32'hC) begin
      errors++;
      $display("FAIL nop_funct got st %0d addr %h want 0 c", dbg_state, mem_addr);
    end
    wait_cycle(25);
`endif
    check_stores_done("illegal");
  endtask

  task automatic test_reset_mid_store();
    hold_reset();
    store_stall = 1'b1;
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
    mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h70);
    mem[2] = spin();
    release_reset();
    wait_cycle(8);
    checks++;
    if ({dbg_state, mem_req, mem_we, mem_addr, mem_wdata} !== {S_MEM, 2'b11, 32'h70, 32'd7}) begin
      errors++;
      $display("FAIL midrst_pending got st %0d %b%b %h %h want 3 11 70 7", dbg_state, mem_req, mem_we, mem_addr, mem_wdata);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b00, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL midrst_drop got %b%b %h %h want 00 0 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (pc_out !== RESET_PC || dbg_state !== S_FETCH) begin
      errors++;
      $display("FAIL midrst_pc got pc %h st %0d want %h 0", pc_out, dbg_state, RESET_PC);
    end
    step();
    step();
    mem[0] = spin();
    store_stall = 1'b0;
    release_reset();
    wait_cycle(20);
    check_stores_done("midrst");
  endtask

  task automatic test_back_to_back();
    hold_reset();
    rand_delay = 1'b1;
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd10);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h80);
    mem[4] = enc_i(6'h23, 5'd0, 5'd4, 16'h80);
    mem[5] = enc_r(5'd1, 5'd2, 5'd5, 6'h2A);
    mem[6] = enc_r(5'd4, 5'd5, 5'd6, 6'h22);
    mem[7] = enc_i(6'h2B, 5'd0, 5'd6, 16'h84);
    mem[8] = enc_i(6'h2B, 5'd0, 5'd5, 16'h88);
    mem[9] = spin();
    exp_q.push_back({32'h80, 32'd7});
    exp_q.push_back({32'h84, 32'd6});
    exp_q.push_back({32'h88, 32'd1});
    release_reset();
    wait_cycle(200);
    check_stores_done("back_to_back");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset       = 1'b0;
    mem_ready   = 1'b0;
    mem_rdata   = 32'd0;
    cyc         = 0;
    wait_cnt    = 0;
    ready_delay = 0;
    store_stall = 1'b0;
    rand_delay  = 1'b0;
    test_reset();
    test_arith();
    test_mem_wait();
    test_branch();
    test_jump();
    test_alu();
    test_illegal();
    test_reset_mid_store();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and mem_addr (legal 8..32).
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset (word aligned).
REQ-003 clock  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  memory access request, held until accepted.
REQ-006 mem_we  output  1  1 = store, 0 = fetch or load.
REQ-007 mem_addr  output  ADDR_W  byte address of access.
REQ-008 mem_wdata  output  32  store data (rt value).
REQ-009 mem_rdata  input  32  read data, valid in the cycle mem_ready=1.
REQ-010 mem_ready  input  1  access accepted/completed this cycle.
REQ-011 instr  output  32  instruction currently executing (latched at fetch).
REQ-012 pc_out  output  ADDR_W  current PC.
REQ-013 halted  output  1  core stopped (ILLEGAL_TRAP_EN only, else tied 0).

Function
REQ-014 The core SHALL be a multi-cycle MIPS subset: add, sub, and, or, slt (R-type, funct 0x20/0x22/0x24/0x25/0x2A), addi (0x08), lw (0x23), sw (0x2B), beq (0x04), j (0x02).
REQ-015 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready, instr<=mem_rdata, pc<=pc+4, go DECODE; else stay with outputs stable.
REQ-017 DECODE: read rs/rt from 32x32 register file, sign-extend imm16; always 1 cycle, go EXEC.
REQ-018 EXEC: R-type/addi -> WB; lw/sw compute rs+simm, go MEM; beq: if rs==rt pc<=pc+(simm<<2), go FETCH; j: pc<={pc[ADDR_W-1:28] if ADDR_W>28, target26<<2} truncated to ADDR_W, go FETCH.
REQ-019 MEM: mem_req=1, mem_addr=ALU result[ADDR_W-1:0], mem_we=1 for sw with mem_wdata=rt; address/data/we SHALL stay stable until mem_ready; lw -> WB capturing mem_rdata; sw -> FETCH.
REQ-020 WB: write rd (R-type) or rt (addi/lw); writes to register 0 SHALL be discarded and r0 SHALL read 0; go FETCH.
REQ-021 Zero-wait latencies (mem_ready=1 first cycle): R-type/addi 4, lw 5, sw 4, beq 3, j 3 cycles.
REQ-022 Arithmetic SHALL wrap modulo 2^32 with no overflow trap; slt is signed; PC arithmetic wraps modulo 2^ADDR_W.
REQ-023 mem_req SHALL be 0 in DECODE, EXEC, WB, HALT; register writes SHALL occur only in WB.
REQ-024 Unsupported opcode/funct SHALL be handled per REQ-030/031.

Reset
REQ-025 While reset=0: state=FETCH, pc=RESET_PC, all registers 0, instr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
REQ-026 Reset asserted mid-access SHALL drop mem_req immediately (asynchronously); a pending store SHALL not be reissued.
REQ-027 First fetch SHALL request RESET_PC in the first rising edge cycle after reset deasserts.

Configuration
REQ-028 Macro ILLEGAL_TRAP_EN selects illegal-instruction behaviour.
REQ-029 Defined: illegal instruction in EXEC -> HALT; halted=1; pc holds address of following instruction; only reset exits HALT.
REQ-030 Defined: halted rises the cycle after EXEC of the illegal instruction and stays 1.
REQ-031 Undefined: illegal instruction SHALL execute as NOP (EXEC -> FETCH, 3 cycles), HALT unreachable, halted constant 0.

Verification
REQ-032 Reset, mem_ready=1, program addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12 after 12 cycles, r0 write ignored.
REQ-033 sw r3,4(r0) then lw r4,4(r0) with mem_ready delayed 3 cycles each -> mem_addr=4, mem_wdata=12 held stable, r4=12.
REQ-034 beq r1,r1,-1 -> pc returns to beq address every 3 cycles; beq r1,r2 (unequal) -> pc+4.
REQ-035 j 0x40 at pc 0x10 -> next fetch mem_addr=0x100; add 0x7FFFFFFF+1 -> 0x80000000, slt of it vs 0 -> 1.
REQ-036 Opcode 0x3F: with ILLEGAL_TRAP_EN halted=1 and mem_req stays 0; without it next fetch at pc+4.
REQ-037 reset=0 asserted during MEM of sw with mem_ready=0 -> mem_req falls same cycle, pc=RESET_PC, no write seen.
